// File: rtl/key_debounce.sv
// key_debounce: multi-channel key/switch debouncer.
// Each raw level passes through a 2-flop synchroniser. A shared free-running
// prescaler produces a sample tick, and a per-channel counter qualifies a new
// level only after STABLE_TICKS consecutive ticks that disagree with the
// current output. o_Changed pulses for one cycle on any committed change.
module key_debounce #(
  parameter int WIDTH        = 8,
  parameter int TICK_CYCLES  = 1000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Keys,
  output logic [WIDTH-1:0] o_Keys,
  output logic             o_Changed
);

  // Counters keep at least one bit so the degenerate 1/1 configuration still
  // elaborates to a plain synchroniser plus output register.
  localparam int PW = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)  : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1_q;
  logic [WIDTH-1:0]         sync2_q;

  logic [PW-1:0]            presc_q;
  logic [PW-1:0]            presc_d;
  logic                     tick;

  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;

  logic [WIDTH-1:0]         keys_q;
  logic [WIDTH-1:0]         keys_d;
  logic [WIDTH-1:0]         commit;

  logic                     changed_q;
  logic                     changed_d;

  // Two-stage synchroniser; only the second stage feeds the filter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Keys;
      sync2_q <= sync1_q;
    end
  end

  // Tick on the last prescaler count; the prescaler is never held.
  assign tick = (presc_q == PRESC_LAST);

  // Prescaler next count: wrap to zero on the tick edge, otherwise advance.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-channel qualification: any agreeing tick restarts from zero, the
  // STABLE_TICKS-th consecutive disagreeing tick commits the new level.
  always_comb begin
    cnt_d  = cnt_q;
    keys_d = keys_q;
    commit = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == keys_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          keys_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
          commit[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Simultaneous commits on one tick collapse into a single strobe.
  always_comb begin
    changed_d = |commit;
  end

  // Channel counters, debounced levels and change strobe.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q     <= '0;
      keys_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      changed_q <= changed_d;
    end
  end

  assign o_Keys    = keys_q;
  assign o_Changed = changed_q;

endmodule
